// File: rtl/ps2_mouse_master_fsm_pkg.sv
// Shared definitions for the PS/2 mouse master: state codes, the PS/2 command
// and response bytes, and a helper for the "wait for one expected byte" states.
package ps2_mouse_master_fsm_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WAIT        = 4'd0,
    ST_SEND_RESET       = 4'd1,
    ST_WAIT_SENT_RESET  = 4'd2,
    ST_WAIT_ACK_RESET   = 4'd3,
    ST_WAIT_SELFTEST    = 4'd4,
    ST_WAIT_ID          = 4'd5,
    ST_SEND_ENABLE      = 4'd6,
    ST_WAIT_SENT_ENABLE = 4'd7,
    ST_WAIT_ACK_ENABLE  = 4'd8,
    ST_READ_STATUS      = 4'd9,
    ST_READ_DX          = 4'd10,
    ST_READ_DY          = 4'd11,
    ST_INTERRUPT        = 4'd12
  } state_t;

  localparam logic [7:0] CMD_RESET         = 8'hFF;
  localparam logic [7:0] CMD_ENABLE_REPORT = 8'hF4;
  localparam logic [7:0] RSP_ACK           = 8'hFA;
  localparam logic [7:0] RSP_SELFTEST_OK   = 8'hAA;
  localparam logic [7:0] RSP_MOUSE_ID      = 8'h00;

  // A received byte always beats a timeout landing in the same cycle.
  function automatic state_t next_on_response(
    input logic       ready,
    input logic       good,
    input logic [7:0] data,
    input logic [7:0] want,
    input logic       timed_out,
    input state_t     here,
    input state_t     target
  );
    if (ready)
      return (good && data == want) ? target : ST_INIT_WAIT;
    if (timed_out)
      return ST_INIT_WAIT;
    return here;
  endfunction

endpackage

// File: rtl/ps2_mouse_master_fsm.sv
// PS/2 mouse master: power-up handshake, then streams 3-byte movement packets
// onto MOUSE_* with a one-cycle SEND_INTERRUPT per packet.
module ps2_mouse_master_fsm
  import ps2_mouse_master_fsm_pkg::*;
#(
  parameter int unsigned INIT_WAIT    = 5_000_000,
  parameter int unsigned RESP_TIMEOUT = 10_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] CURR_STATE
);

  state_t      state;
  state_t      state_next;
  logic [31:0] count;
  logic [7:0]  status_q;
  logic [7:0]  dx_q;
  logic        good;
  logic        timed_out;

  assign good       = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign timed_out  = (count == RESP_TIMEOUT);
  assign CURR_STATE = state;

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT_WAIT:        if (count == INIT_WAIT) state_next = ST_SEND_RESET;
      ST_SEND_RESET:       state_next = ST_WAIT_SENT_RESET;
      ST_WAIT_SENT_RESET:  if (BYTE_SENT) state_next = ST_WAIT_ACK_RESET;
                           else if (timed_out) state_next = ST_INIT_WAIT;
      ST_WAIT_ACK_RESET:   state_next = next_on_response(BYTE_READY, good, BYTE_READ, RSP_ACK,
                                                         timed_out, state, ST_WAIT_SELFTEST);
      ST_WAIT_SELFTEST:    state_next = next_on_response(BYTE_READY, good, BYTE_READ, RSP_SELFTEST_OK,
                                                         timed_out, state, ST_WAIT_ID);
      ST_WAIT_ID:          state_next = next_on_response(BYTE_READY, good, BYTE_READ, RSP_MOUSE_ID,
                                                         timed_out, state, ST_SEND_ENABLE);
      ST_SEND_ENABLE:      state_next = ST_WAIT_SENT_ENABLE;
      ST_WAIT_SENT_ENABLE: if (BYTE_SENT) state_next = ST_WAIT_ACK_ENABLE;
                           else if (timed_out) state_next = ST_INIT_WAIT;
      ST_WAIT_ACK_ENABLE:  state_next = next_on_response(BYTE_READY, good, BYTE_READ, RSP_ACK,
                                                         timed_out, state, ST_READ_STATUS);
      // The mouse only reports on motion, so the status byte may never come.
      ST_READ_STATUS:      if (BYTE_READY) state_next = good ? ST_READ_DX : ST_INIT_WAIT;
      ST_READ_DX:          if (BYTE_READY) state_next = good ? ST_READ_DY : ST_INIT_WAIT;
                           else if (timed_out) state_next = ST_INIT_WAIT;
      ST_READ_DY:          if (BYTE_READY) state_next = good ? ST_INTERRUPT : ST_INIT_WAIT;
                           else if (timed_out) state_next = ST_INIT_WAIT;
      ST_INTERRUPT:        state_next = ST_READ_STATUS;
      default:             state_next = ST_INIT_WAIT;
    endcase
  end

  // Outputs are decoded from state_next so each one is a flop aligned with state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= ST_INIT_WAIT;
      count          <= '0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= 8'h00;
      READ_ENABLE    <= 1'b0;
      MOUSE_STATUS   <= 8'h00;
      MOUSE_DX       <= 8'h00;
      MOUSE_DY       <= 8'h00;
      SEND_INTERRUPT <= 1'b0;
      status_q       <= 8'h00;
      dx_q           <= 8'h00;
    end else begin
      state          <= state_next;
      count          <= (state_next != state) ? '0 : count + 32'd1;
      SEND_BYTE      <= (state_next == ST_SEND_RESET) || (state_next == ST_SEND_ENABLE);
      READ_ENABLE    <= state_next inside {ST_WAIT_ACK_RESET, ST_WAIT_SELFTEST, ST_WAIT_ID,
                                           ST_WAIT_ACK_ENABLE, ST_READ_STATUS, ST_READ_DX,
                                           ST_READ_DY};
      SEND_INTERRUPT <= (state_next == ST_INTERRUPT);

      if (state_next == ST_SEND_RESET)
        BYTE_TO_SEND <= CMD_RESET;
      else if (state_next == ST_SEND_ENABLE)
        BYTE_TO_SEND <= CMD_ENABLE_REPORT;

      if (state == ST_READ_STATUS && good)
        status_q <= BYTE_READ;
      if (state == ST_READ_DX && good)
        dx_q <= BYTE_READ;
      if (state == ST_READ_DY && good) begin
        MOUSE_STATUS <= status_q;
        MOUSE_DX     <= dx_q;
        MOUSE_DY     <= BYTE_READ;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_master_fsm.sv
// Self-checking bench for ps2_mouse_master_fsm: directed handshake/fault cases
// plus randomized packets, aborts and timeouts against a transaction-level model.
module tb_ps2_mouse_master_fsm;

  localparam int INIT_WAIT    = 20;
  localparam int RESP_TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent = 1'b0;
  logic       read_enable;
  logic [7:0] byte_read = 8'h00;
  logic [1:0] byte_error_code = 2'b00;
  logic       byte_ready = 1'b0;
  logic [7:0] mouse_status;
  logic [7:0] mouse_dx;
  logic [7:0] mouse_dy;
  logic       send_interrupt;
  logic [3:0] curr_state;

  int n_checks = 0;
  int n_errors = 0;
  int irq_count = 0;
  int exp_irq = 0;
  logic [7:0] exp_status = 8'h00;
  logic [7:0] exp_dx = 8'h00;
  logic [7:0] exp_dy = 8'h00;

  ps2_mouse_master_fsm #(
    .INIT_WAIT   (INIT_WAIT),
    .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .CLK            (clk),
    .RESET          (reset),
    .SEND_BYTE      (send_byte),
    .BYTE_TO_SEND   (byte_to_send),
    .BYTE_SENT      (byte_sent),
    .READ_ENABLE    (read_enable),
    .BYTE_READ      (byte_read),
    .BYTE_ERROR_CODE(byte_error_code),
    .BYTE_READY     (byte_ready),
    .MOUSE_STATUS   (mouse_status),
    .MOUSE_DX       (mouse_dx),
    .MOUSE_DY       (mouse_dy),
    .SEND_INTERRUPT (send_interrupt),
    .CURR_STATE     (curr_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (send_interrupt === 1'b1) irq_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_byte(input logic [7:0] b, input logic [1:0] err);
    byte_read       = b;
    byte_error_code = err;
    byte_ready      = 1'b1;
    tick();
    byte_ready      = 1'b0;
    byte_error_code = 2'b00;
  endtask

  task automatic pulse_sent();
    byte_sent = 1'b1;
    tick();
    byte_sent = 1'b0;
  endtask

  task automatic check_mouse_held(input string tag);
    check({tag, "_status"}, 32'(mouse_status), 32'(exp_status));
    check({tag, "_dx"}, 32'(mouse_dx), 32'(exp_dx));
    check({tag, "_dy"}, 32'(mouse_dy), 32'(exp_dy));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(curr_state), 0);
    check({tag, "_send"}, 32'(send_byte), 0);
    check({tag, "_tx_byte"}, 32'(byte_to_send), 0);
    check({tag, "_rd_en"}, 32'(read_enable), 0);
    check({tag, "_status"}, 32'(mouse_status), 0);
    check({tag, "_dx"}, 32'(mouse_dx), 0);
    check({tag, "_dy"}, 32'(mouse_dy), 0);
    check({tag, "_irq"}, 32'(send_interrupt), 0);
  endtask

  task automatic feed_rsp(input logic [7:0] b, input int next_state);
    idle($urandom_range(0, 20));
    pulse_byte(b, 2'b00);
    check("rsp_state", 32'(curr_state), next_state);
  endtask

  // Starts in state 0. fault: 0 none, 1 sent-timeout in state 2,
  // 2 bad self-test byte, 3 stray BYTE_READY while the receiver is disabled.
  task automatic handshake(input int fault);
    int n;
    n = 0;
    while (send_byte !== 1'b1 && n < INIT_WAIT + 10) begin
      tick();
      n++;
    end
    check("init_wait_cycles", n, INIT_WAIT + 1);
    check("send_rst_state", 32'(curr_state), 1);
    check("send_rst_byte", 32'(byte_to_send), 32'hFF);
    check("send_rst_rd_en", 32'(read_enable), 0);
    tick();
    check("send_rst_one_cycle", 32'(send_byte), 0);
    check("wait_sent_state", 32'(curr_state), 2);
    if (fault == 1) begin
      idle(RESP_TIMEOUT);
      check("sent_timeout_edge", 32'(curr_state), 2);
      tick();
      check("sent_timeout_abort", 32'(curr_state), 0);
      check("sent_timeout_rd_en", 32'(read_enable), 0);
      return;
    end
    if (fault == 3) begin
      pulse_byte(8'hFA, 2'b00);
      check("ignored_ready_state", 32'(curr_state), 2);
      check("ignored_ready_rd_en", 32'(read_enable), 0);
    end
    idle($urandom_range(0, 20));
    pulse_sent();
    check("ack_rst_state", 32'(curr_state), 3);
    check("ack_rst_rd_en", 32'(read_enable), 1);
    feed_rsp(8'hFA, 4);
    if (fault == 2) begin
      pulse_byte(8'hFC, 2'b00);
      check("bad_selftest_abort", 32'(curr_state), 0);
      return;
    end
    feed_rsp(8'hAA, 5);
    feed_rsp(8'h00, 6);
    check("send_en_pulse", 32'(send_byte), 1);
    check("send_en_byte", 32'(byte_to_send), 32'hF4);
    check("send_en_rd_en", 32'(read_enable), 0);
    tick();
    check("wait_sent_en_state", 32'(curr_state), 7);
    check("send_en_one_cycle", 32'(send_byte), 0);
    check("send_en_byte_held", 32'(byte_to_send), 32'hF4);
    idle($urandom_range(0, 20));
    pulse_sent();
    check("ack_en_state", 32'(curr_state), 8);
    feed_rsp(8'hFA, 9);
    check("streaming_rd_en", 32'(read_enable), 1);
    check("handshake_no_irq", irq_count, exp_irq);
  endtask

  task automatic send_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy,
                             input int gap_dx, input int gap_dy);
    idle($urandom_range(0, 40));
    pulse_byte(s, 2'b00);
    check("pkt_dx_state", 32'(curr_state), 10);
    idle(gap_dx);
    pulse_byte(dx, 2'b00);
    check("pkt_dy_state", 32'(curr_state), 11);
    check_mouse_held("pkt_mid");
    idle(gap_dy);
    pulse_byte(dy, 2'b00);
    exp_status = s;
    exp_dx     = dx;
    exp_dy     = dy;
    exp_irq++;
    check("pkt_irq_state", 32'(curr_state), 12);
    check("pkt_irq", 32'(send_interrupt), 1);
    check_mouse_held("pkt_out");
    tick();
    check("pkt_back_state", 32'(curr_state), 9);
    check("pkt_irq_one_cycle", 32'(send_interrupt), 0);
    check("pkt_irq_count", irq_count, exp_irq);
  endtask

  // Feeds good bytes up to position pos (0..2), then aborts there.
  task automatic abort_packet(input int pos, input logic use_timeout);
    if (pos >= 1) pulse_byte(8'($urandom), 2'b00);
    if (pos >= 2) pulse_byte(8'($urandom), 2'b00);
    if (use_timeout) idle(RESP_TIMEOUT + 1);
    else pulse_byte(8'($urandom), 2'($urandom_range(1, 3)));
    check("abort_state", 32'(curr_state), 0);
    check("abort_irq_count", irq_count, exp_irq);
    check_mouse_held("abort_hold");
  endtask

  initial begin
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;

    handshake(3);
    send_packet(8'h28, 8'h05, 8'hFB, 0, 0);

    idle(RESP_TIMEOUT + 50);
    check("status_no_timeout", 32'(curr_state), 9);
    send_packet(8'h3C, 8'h81, 8'h7F, RESP_TIMEOUT, RESP_TIMEOUT);

    abort_packet(1, 1'b0);
    handshake(2);
    handshake(1);
    handshake(0);

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0, 1: send_packet(8'($urandom), 8'($urandom), 8'($urandom),
                          $urandom_range(0, 60), $urandom_range(0, 60));
        2: begin
          abort_packet($urandom_range(0, 2), 1'b0);
          handshake(0);
        end
        default: begin
          abort_packet($urandom_range(1, 2), 1'b1);
          handshake(0);
        end
      endcase
    end

    send_packet(8'h28, 8'h05, 8'hFB, 3, 7);
    pulse_byte(8'h11, 2'b00);
    pulse_byte(8'h22, 2'b00);
    check("pre_reset_state", 32'(curr_state), 11);
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    exp_status = 8'h00;
    exp_dx     = 8'h00;
    exp_dy     = 8'h00;
    handshake(0);
    send_packet(8'h09, 8'hFF, 8'h01, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_master_fsm.md
Name: ps2_mouse_master_fsm

Overview:
- Master controller for a PS/2 mouse link.
- Sits between the byte-level transmitter/receiver pair and the position/pre-processing logic of the mouse transceiver.
- Runs the power-up handshake (reset, self-test, device ID, enable streaming), then continuously collects 3-byte movement packets.
- Publishes each packet (status, dX, dY) with a one-cycle interrupt pulse.

Parameters:
- INIT_WAIT, 5_000_000, clock cycles to wait after reset or re-initialisation before sending the reset command (50 ms @ 100 MHz).
- RESP_TIMEOUT, 10_000_000, max cycles in any wait-for-byte or wait-for-sent state before aborting to state 0 (100 ms @ 100 MHz).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- SEND_BYTE  out  1  one-cycle request to the transmitter
- BYTE_TO_SEND  out  8  command byte for the transmitter; held stable while sending
- BYTE_SENT  in  1  transmitter completion pulse
- READ_ENABLE  out  1  enables the receiver
- BYTE_READ  in  8  received byte
- BYTE_ERROR_CODE  in  2  receiver error; 00 = good, nonzero = parity/stop error
- BYTE_READY  in  1  one-cycle pulse; BYTE_READ and BYTE_ERROR_CODE are valid
- MOUSE_STATUS  out  8  last packet byte 1
- MOUSE_DX  out  8  last packet byte 2
- MOUSE_DY  out  8  last packet byte 3
- SEND_INTERRUPT  out  1  one-cycle pulse; a new packet is on the MOUSE_* outputs
- CURR_STATE  out  4  current state code, for debug

Behaviour:
- All outputs are registered.
- Reset values: state 0; counter 0; SEND_BYTE 0; BYTE_TO_SEND 00; READ_ENABLE 0; MOUSE_STATUS, MOUSE_DX, MOUSE_DY 00; SEND_INTERRUPT 0.
- One free-running counter, cleared on every state change.
- A "good byte" is BYTE_READY=1 with BYTE_ERROR_CODE=00.
- States:
  - 0 INIT_WAIT: go to 1 when counter == INIT_WAIT.
  - 1 SEND_RESET: BYTE_TO_SEND=FF, SEND_BYTE=1 for one cycle; go to 2.
  - 2 WAIT_SENT_RESET: on BYTE_SENT go to 3; on timeout go to 0.
  - 3 WAIT_ACK_RESET: READ_ENABLE=1. Good byte FA → 4; any other byte or error → 0; timeout → 0.
  - 4 WAIT_SELFTEST: good byte AA → 5; otherwise as state 3.
  - 5 WAIT_ID: good byte 00 → 6; otherwise as state 3.
  - 6 SEND_ENABLE: BYTE_TO_SEND=F4, SEND_BYTE=1 for one cycle; go to 7.
  - 7 WAIT_SENT_ENABLE: as state 2, next state 8.
  - 8 WAIT_ACK_ENABLE: good byte FA → 9; otherwise as state 3.
  - 9 READ_STATUS: READ_ENABLE=1. Good byte is stored internally → 10; error → 0. No timeout here; the mouse only reports on motion.
  - 10 READ_DX: good byte stored → 11; error → 0; timeout → 0.
  - 11 READ_DY: good byte → 12. On that same edge, the stored status, stored dx and the dy byte load into MOUSE_STATUS/DX/DY. Error → 0; timeout → 0.
  - 12 INTERRUPT: SEND_INTERRUPT=1 for exactly this one cycle; MOUSE_* are already valid; go to 9.
- MOUSE_* change only on the 11→12 edge. Aborted packets leave them unchanged.
- SEND_INTERRUPT is never asserted outside state 12.
- READ_ENABLE is high only in states 3, 4, 5, 8, 9, 10, 11.
- BYTE_READY while READ_ENABLE=0 is ignored.
- BYTE_READY and a timeout in the same cycle: BYTE_READY wins.
- RESET mid-operation: returns to state 0 next edge with all outputs at reset values.
- States 13–15 are unreachable; if entered, go to 0.

Decomposition:
- Shared package holds:
  - the 4-bit state encoding constants, values 0–12;
  - PS/2 constants: CMD_RESET=FF, CMD_ENABLE_REPORT=F4, RSP_ACK=FA, RSP_SELFTEST_OK=AA, RSP_MOUSE_ID=00.
- Single module; no sub-module is needed. The counter stays inline.

Test Plan (INIT_WAIT=20, RESP_TIMEOUT=100):
- Reset, then the full handshake (BYTE_SENT, then FA, AA, 00; BYTE_SENT, then FA) → SEND_BYTE pulses with BYTE_TO_SEND=FF, then with F4. CURR_STATE walks 0..9. No SEND_INTERRUPT.
- In state 9, feed 28, 05, FB as good bytes → one-cycle SEND_INTERRUPT with MOUSE_STATUS=28, MOUSE_DX=05, MOUSE_DY=FB. CURR_STATE returns to 9.
- In state 4, feed FC → next state 0. After 20 cycles SEND_BYTE fires again with BYTE_TO_SEND=FF.
- In state 10, BYTE_ERROR_CODE=01 with BYTE_READY → state 0. MOUSE_* keep their prior packet values. No interrupt.
- In state 2, withhold BYTE_SENT for 100+ cycles → state 0.
- Assert RESET while in state 11 → all outputs 00, CURR_STATE=0.
